// File: rtl/ioctl_pkg.sv
// rtl/ioctl_pkg.sv - shared types and constants for the ioctl download master
package ioctl_pkg;

  localparam int         IOCTL_ADDR_W = 25;
  localparam int         CNT_W        = 8;
  localparam logic [7:0] IDX_BIOS     = 8'd0;
  localparam logic [7:0] IDX_CART     = 8'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_FETCH,
    ST_WRITE,
    ST_GAP,
    ST_TAIL
  } dl_state_t;

endpackage

// File: rtl/ioctl_download_master.sv
// rtl/ioctl_download_master.sv - streams source bytes onto the ioctl download bus
// Optional byte checksum built only when IOCTL_CHECKSUM_EN is defined.
module ioctl_download_master
  import ioctl_pkg::*;
#(
  parameter int ADDR_W   = IOCTL_ADDR_W,
  parameter int WR_GAP   = 2,
  parameter int TAIL_CYC = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        index_in,
  input  logic [ADDR_W-1:0] length,
  input  logic              src_valid,
  input  logic [7:0]        src_data,
  output logic              src_ready,
  output logic              ioctl_download,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_index,
  input  logic              ioctl_wait,
  output logic              busy,
  output logic              done,
  output logic [7:0]        checksum
);

  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(WR_GAP - 1);
  localparam logic [CNT_W-1:0]  TAIL_LOAD = CNT_W'(TAIL_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;

  dl_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        dout_q, dout_d;
  logic              armed_q;
  logic              start_ok;

  // armed_q blocks a start that coincides with the edge releasing reset
  assign start_ok = (state_q == ST_IDLE) && start && armed_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    len_d     = len_q;
    idx_d     = idx_q;
    dout_d    = dout_q;
    src_ready = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          idx_d   = index_in;
          len_d   = length;
          addr_d  = '0;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        cnt_d   = TAIL_LOAD;
        state_d = (len_q == '0) ? ST_TAIL : ST_FETCH;
      end
      ST_FETCH: begin
        src_ready = 1'b1;
        if (src_valid) begin
          dout_d  = src_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cnt_d   = GAP_LOAD;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        // Back-pressure only counts once the minimum gap has elapsed
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!ioctl_wait) begin
          if (addr_q == len_q - ADDR_ONE) begin
            cnt_d   = TAIL_LOAD;
            state_d = ST_TAIL;
          end else begin
            addr_d  = addr_q + ADDR_ONE;
            state_d = ST_FETCH;
          end
        end
      end
      ST_TAIL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ioctl_download = (state_q != ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign ioctl_wr       = (state_q == ST_WRITE);
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;
  assign ioctl_index    = idx_q;

`ifdef IOCTL_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (start_ok) begin
      sum_d = '0;
    end else if (state_q == ST_WRITE) begin
      sum_d = sum_q + dout_q;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_ioctl_download_master.sv
// tb/tb_ioctl_download_master.sv - self-checking bench for ioctl_download_master
module tb_ioctl_download_master;

  localparam int AW   = 25;
  localparam int GAP  = 2;
  localparam int TAIL = 4;
  localparam int MAXC = 128;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [7:0]    index_in;
  logic [AW-1:0] length;
  logic          src_valid;
  logic [7:0]    src_data;
  logic          src_ready;
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic [7:0]    ioctl_index;
  logic          ioctl_wait;
  logic          busy;
  logic          done;
  logic [7:0]    checksum;

  always #5 clk = ~clk;

  ioctl_download_master #(.ADDR_W(AW), .WR_GAP(GAP), .TAIL_CYC(TAIL)) dut (
    .clk_sys(clk), .reset_n(reset_n), .start(start), .index_in(index_in),
    .length(length), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .ioctl_wait(ioctl_wait), .busy(busy), .done(done), .checksum(checksum)
  );

  int         errors = 0;
  int         checks = 0;
  int         rel    = 0;
  bit         chk_en = 1'b0;
  bit         valid_tab [MAXC];
  bit         wait_tab  [MAXC];
  bit         exp_wr    [MAXC];
  int         exp_addr  [MAXC];
  logic [7:0] exp_dout  [MAXC];
  logic [7:0] exp_sum   [MAXC];
  int         exp_done;
  logic [7:0] exp_idx;
  logic [7:0] bytes [16];
  int         obs_wr [16];
  int         nobs, obs_done, ndone, ndl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s rel=%0d actual=%0h expected=%0h", name, rel, act, exp);
    end
  endtask

  task automatic zero_chk();
    chk("rst_download", ioctl_download, 0);
    chk("rst_wr", ioctl_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", ioctl_addr, 0);
    chk("rst_dout", ioctl_dout, 0);
    chk("rst_index", ioctl_index, 0);
    chk("rst_ready", src_ready, 0);
    chk("rst_checksum", checksum, 0);
  endtask

  // Compare process: DUT outputs against the expected timeline, every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      bit dl;
      dl = (rel >= 1) && (rel <= exp_done);
      chk("download", ioctl_download, dl);
      chk("busy", busy, dl);
      chk("wr", ioctl_wr, exp_wr[rel]);
      chk("done", done, rel == exp_done);
      if (dl) chk("index", ioctl_index, exp_idx);
      if (exp_wr[rel]) begin
        chk("addr", ioctl_addr, exp_addr[rel]);
        chk("dout", ioctl_dout, exp_dout[rel]);
      end
      if (rel + 1 < MAXC && exp_wr[rel+1]) chk("addr_pre", ioctl_addr, exp_addr[rel+1]);
      if (rel >= 1) chk("checksum", checksum, exp_sum[rel]);
      if (ioctl_wr === 1'b1 && nobs < 16) begin
        obs_wr[nobs] = rel;
        nobs++;
      end
      if (done === 1'b1) begin
        obs_done = rel;
        ndone++;
      end
      if (ioctl_download === 1'b1) ndl++;
    end
  end

  // Build the expected timeline from the protocol rules, then drive one download
  task automatic run(input int len, input logic [7:0] idx, input int restart_at,
                     input int vlo, input int vhi, input int wlo, input int whi,
                     input int abort_at);
    int f, c, w, e, ptr;
    bit hs;
    logic [7:0] s;
    for (int i = 0; i < MAXC; i++) begin
      valid_tab[i] = !(i >= vlo && i <= vhi);
      wait_tab[i]  = (i >= wlo && i <= whi);
      exp_wr[i]    = 1'b0;
      exp_addr[i]  = 0;
      exp_dout[i]  = 8'h00;
    end
    f = 2;
    for (int k = 0; k < len; k++) begin
      c = f;
      while (c < MAXC - 8 && !valid_tab[c]) c++;
      w = c + 1;
      exp_wr[w]   = 1'b1;
      exp_addr[w] = k;
      exp_dout[w] = bytes[k];
      e = w + GAP;
      while (e < MAXC - 8 && wait_tab[e]) e++;
      f = e + 1;
    end
    exp_done = f + TAIL - 1;
    s = 8'h00;
    exp_sum[0] = 8'h00;
    for (int r = 1; r < MAXC; r++) begin
`ifdef IOCTL_CHECKSUM_EN
      if (exp_wr[r-1]) s = s + exp_dout[r-1];
`endif
      exp_sum[r] = s;
    end
    exp_idx  = idx;
    nobs     = 0;
    ndone    = 0;
    ndl      = 0;
    obs_done = -1;
    ptr      = 0;
    hs       = 1'b0;

    @(posedge clk); #1;
    rel = 0;
    start = 1'b1; index_in = idx; length = AW'(len);
    src_valid = valid_tab[0]; ioctl_wait = wait_tab[0];
    src_data = valid_tab[0] ? bytes[ptr] : 8'h5A;
    chk_en = 1'b1;
    for (int r = 0; r <= exp_done + 2; r++) begin
      if (r > 0) begin
        @(posedge clk);
        if (hs && ptr < 15) ptr++;
        #1;
        rel = r;
        start = (r == restart_at);
        if (r == restart_at) begin
          index_in = 8'h77;
          length   = AW'(9);
        end
        src_valid  = valid_tab[r];
        ioctl_wait = wait_tab[r];
        src_data   = valid_tab[r] ? bytes[ptr] : 8'h5A;
      end
      @(negedge clk);
      hs = src_valid && src_ready;
      if (r == abort_at) begin
        chk_en = 1'b0;
        #2 reset_n = 1'b0;
        #1 zero_chk();
        start = 1'b0;
        return;
      end
    end
    chk_en = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; index_in = 8'h00; length = '0;
    src_valid = 1'b0; src_data = 8'h00; ioctl_wait = 1'b0;
    repeat (2) @(posedge clk);
    #1 zero_chk();
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: plain length 4 BIOS load, second start while busy is ignored
    bytes[0] = 8'hA0; bytes[1] = 8'hA1; bytes[2] = 8'hA2; bytes[3] = 8'hA3;
    run(4, 8'h00, 5, -1, -1, -1, -1, -1);
    chk("t1_nwr", nobs, 4);
    chk("t1_wr0", obs_wr[0], 3);
    chk("t1_wr1", obs_wr[1], 7);
    chk("t1_wr2", obs_wr[2], 11);
    chk("t1_wr3", obs_wr[3], 15);
    chk("t1_done", obs_done, 21);

    // 2: back-pressure through the end of the first gap stretches it by 5
    bytes[0] = 8'h10; bytes[1] = 8'h11; bytes[2] = 8'h12;
    run(3, 8'h02, -1, -1, -1, 5, 9, -1);
    chk("t2_wr0", obs_wr[0], 3);
    chk("t2_wr1", obs_wr[1], 12);
    chk("t2_wr2", obs_wr[2], 16);

    // 2b: wait during the strobe and early gap has no effect
    bytes[0] = 8'h21; bytes[1] = 8'h22;
    run(2, 8'h02, -1, -1, -1, 3, 4, -1);
    chk("t2b_wr1", obs_wr[1], 7);

    // 3: zero length cart load
    run(0, 8'h01, -1, -1, -1, -1, -1, -1);
    chk("t3_dl_cycles", ndl, 1 + TAIL);
    chk("t3_nwr", nobs, 0);
    chk("t3_ndone", ndone, 1);
    chk("t3_done", obs_done, 5);

    // 4: source stalls for 6 cycles mid-stream
    bytes[0] = 8'h40; bytes[1] = 8'h41; bytes[2] = 8'h42; bytes[3] = 8'h43;
    run(4, 8'h03, -1, 6, 11, -1, -1, -1);
    chk("t4_nwr", nobs, 4);
    chk("t4_wr1", obs_wr[1], 13);

    // 5: reset during the addr=2 gap, then start coinciding with reset release
    for (int i = 0; i < 8; i++) bytes[i] = 8'h50 + 8'(i);
    run(8, 8'h01, -1, -1, -1, -1, -1, 12);
    chk("t5_nwr", nobs, 3);
    start = 1'b1; index_in = 8'h09; length = AW'(3);
    @(negedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_rel_busy", busy, 0);
    chk("t5_rel_download", ioctl_download, 0);
    @(posedge clk); #1;
    chk("t5_rel_busy2", busy, 0);
    bytes[0] = 8'h60; bytes[1] = 8'h61;
    run(2, 8'h01, -1, -1, -1, -1, -1, -1);
    chk("t5b_nwr", nobs, 2);

    // 6: checksum wraps modulo 256
    bytes[0] = 8'hFF; bytes[1] = 8'h02;
    run(2, 8'h01, -1, -1, -1, -1, -1, -1);
`ifdef IOCTL_CHECKSUM_EN
    chk("t6_checksum", checksum, 8'h01);
`else
    chk("t6_checksum", checksum, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
